// File: rtl/jk_mod_counter_pkg.sv
// Shared definitions for the JK-based modulo counter.
// Holds the {J,K} operation encoding and the helpers that map a desired
// bit transition onto a JK excitation pair.
package jk_mod_counter_pkg;

  // Ordered as {J,K}.
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_op_e;

  // Counting excitation: toggle a bit that must change, hold the rest.
  function automatic jk_op_e jk_excite(input logic cur, input logic nxt);
    return (cur != nxt) ? JK_TGL : JK_HOLD;
  endfunction

  // Load excitation: drive every bit explicitly, independent of present state.
  function automatic jk_op_e jk_force(input logic nxt);
    return nxt ? JK_SET : JK_CLR;
  endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control/status bundle of the JK modulo counter.
//   en, up, load, din : operation request (driven by master)
//   q, nq             : present count and its complement
//   tc                : combinational terminal count
//   wrap              : registered one-cycle wrap-around pulse
interface jk_mod_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] nq;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up, load, din,
    input  q, nq, tc, wrap
  );

  modport slave (
    input  en, up, load, din,
    output q, nq, tc, wrap
  );
endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop storage bit.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset (q=0)
//   j,k : excitation, {J,K} = 00 hold, 01 clear, 10 set, 11 toggle
//   q   : stored bit
//   nq  : complement of q
module jk_cell
  import jk_mod_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic nq
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    case ({j, k})
      JK_HOLD: q_d = q_q;
      JK_CLR:  q_d = 1'b0;
      JK_SET:  q_d = 1'b1;
      JK_TGL:  q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  // Reset branch first so unknown J/K during reset cannot reach the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign nq = ~q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter built from WIDTH JK cells.
// Computes the next count from load/en/up, turns it into per-bit J/K
// excitation and lets the cells apply it on the next rising edge.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset (q=0, wrap=0)
//   bus  : slave side of jk_mod_counter_if (en, up, load, din -> q, nq, tc, wrap)
module jk_mod_counter
  import jk_mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input logic            clk,
  input logic            rst,
  jk_mod_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS = 2^WIDTH is representable for the saturation compare.
  localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_cur;
  logic [WIDTH-1:0] nq_cur;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic             wrap_d, wrap_q;

  // Next-state selection; load wins over counting.
  always_comb begin
    q_next = q_cur;
    wrap_d = 1'b0;
    if (bus.load) begin
      q_next = ({1'b0, bus.din} >= ModExt) ? MaxVal : bus.din;
    end else if (bus.en) begin
      if (bus.up) begin
        if (q_cur == MaxVal) begin
          q_next = '0;
          wrap_d = 1'b1;
        end else begin
          q_next = q_cur + WIDTH'(1);
        end
      end else begin
        if (q_cur == '0) begin
          q_next = MaxVal;
          wrap_d = 1'b1;
        end else begin
          q_next = q_cur - WIDTH'(1);
        end
      end
    end
  end

  // Excitation: loads set/clear every bit, counting toggles only changed bits.
  always_comb begin
    jk_op_e op;
    j_vec = '0;
    k_vec = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      op = bus.load ? jk_force(q_next[i]) : jk_excite(q_cur[i], q_next[i]);
      {j_vec[i], k_vec[i]} = op;
    end
  end

  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j_vec[g]),
      .k   (k_vec[g]),
      .q   (q_cur[g]),
      .nq  (nq_cur[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign bus.q    = q_cur;
  assign bus.nq   = nq_cur;
  assign bus.wrap = wrap_q;
  assign bus.tc   = bus.en & ~bus.load & (bus.up ? (q_cur == MaxVal) : (q_cur == '0));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter: default 4-bit mod-10 instance plus a
// 3-bit mod-8 instance for the full-binary-range case.
module tb_jk_mod_counter;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  jk_mod_counter_if #(.WIDTH(4)) bus ();
  jk_mod_counter_if #(.WIDTH(3)) bus8 ();

  jk_mod_counter #(
    .WIDTH   (4),
    .MODULUS (10)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  jk_mod_counter #(
    .WIDTH   (3),
    .MODULUS (8)
  ) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vectors for the up-count run starting at q=0.
  int up_q    [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int up_wrap [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  int up_tc   [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  int dn_q    [4]  = '{9, 8, 7, 6};
  int dn_wrap [4]  = '{1, 0, 0, 0};
  int alt_up  [4]  = '{1, 0, 1, 0};
  int alt_q   [4]  = '{5, 4, 5, 4};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;

    // Reset with unknown controls.
    rst       = 1'b0;
    bus.en    = 1'bx;
    bus.up    = 1'bx;
    bus.load  = 1'bx;
    bus.din   = '0;
    bus8.en   = 1'b0;
    bus8.up   = 1'b0;
    bus8.load = 1'b0;
    bus8.din  = '0;
    #10;
    check("rst_q", 32'(bus.q), 32'd0);
    check("rst_nq", 32'(bus.nq), 32'd15);
    check("rst_wrap", 32'(bus.wrap), 32'd0);
    check("rst_q8", 32'(bus8.q), 32'd0);

    // Up count through the 9->0 wrap.
    bus.en   = 1'b1;
    bus.up   = 1'b1;
    bus.load = 1'b0;
    rst      = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("up_tc%0d", i), 32'(bus.tc), 32'(up_tc[i]));
      tick();
      check($sformatf("up_q%0d", i), 32'(bus.q), 32'(up_q[i]));
      check($sformatf("up_wrap%0d", i), 32'(bus.wrap), 32'(up_wrap[i]));
    end
    check("up_nq", 32'(bus.nq), 32'd13);

    // Load 0 (no wrap), then count down through 0->9.
    bus.load = 1'b1;
    bus.din  = 4'd0;
    tick();
    check("ld0_q", 32'(bus.q), 32'd0);
    check("ld0_wrap", 32'(bus.wrap), 32'd0);
    bus.load = 1'b0;
    bus.up   = 1'b0;
    #1;
    check("dn_tc_at0", 32'(bus.tc), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("dn_q%0d", i), 32'(bus.q), 32'(dn_q[i]));
      check($sformatf("dn_wrap%0d", i), 32'(bus.wrap), 32'(dn_wrap[i]));
      check($sformatf("dn_tc%0d", i), 32'(bus.tc), 32'd0);
    end

    // Loads override counting; saturation; loading MODULUS-1 never wraps.
    bus.up   = 1'b1;
    bus.load = 1'b1;
    bus.din  = 4'd6;
    #1;
    check("ld_tc_blocked", 32'(bus.tc), 32'd0);
    tick();
    check("ld6_q", 32'(bus.q), 32'd6);
    check("ld6_wrap", 32'(bus.wrap), 32'd0);
    bus.din = 4'd13;
    tick();
    check("ld13_sat_q", 32'(bus.q), 32'd9);
    check("ld13_wrap", 32'(bus.wrap), 32'd0);
    bus.din = 4'd9;
    tick();
    check("ld9_q", 32'(bus.q), 32'd9);
    check("ld9_wrap", 32'(bus.wrap), 32'd0);
    bus.load = 1'b0;
    #1;
    check("ld9_tc", 32'(bus.tc), 32'd1);
    tick();
    check("ld9_up_q", 32'(bus.q), 32'd0);
    check("ld9_up_wrap", 32'(bus.wrap), 32'd1);
    tick();
    check("ld9_up2_q", 32'(bus.q), 32'd1);
    check("ld9_up2_wrap", 32'(bus.wrap), 32'd0);

    // Hold at 4.
    bus.load = 1'b1;
    bus.din  = 4'd4;
    tick();
    bus.load = 1'b0;
    bus.en   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("hold_tc%0d", i), 32'(bus.tc), 32'd0);
      tick();
      check($sformatf("hold_q%0d", i), 32'(bus.q), 32'd4);
    end

    // Direction alternating every edge.
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.up = alt_up[i][0];
      tick();
      check($sformatf("alt_q%0d", i), 32'(bus.q), 32'(alt_q[i]));
    end

    // Mid-count reset at q=7.
    bus.load = 1'b1;
    bus.din  = 4'd0;
    tick();
    bus.load = 1'b0;
    bus.up   = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("mid_q7", 32'(bus.q), 32'd7);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_q", 32'(bus.q), 32'd0);
    check("mid_rst_nq", 32'(bus.nq), 32'd15);
    check("mid_rst_wrap", 32'(bus.wrap), 32'd0);
    #2;
    rst = 1'b1;
    tick();
    check("mid_after_q", 32'(bus.q), 32'd1);
    check("mid_after_wrap", 32'(bus.wrap), 32'd0);

    // Reset kills a pending wrap pulse.
    bus.load = 1'b1;
    bus.din  = 4'd9;
    tick();
    bus.load = 1'b0;
    tick();
    check("wr_rst_pre", 32'(bus.wrap), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("wr_rst_wrap", 32'(bus.wrap), 32'd0);
    check("wr_rst_q", 32'(bus.q), 32'd0);
    #2;
    rst = 1'b1;

    // Full binary range, WIDTH=3 MODULUS=8.
    bus8.load = 1'b1;
    bus8.din  = 3'd7;
    tick();
    check("f8_ld_q", 32'(bus8.q), 32'd7);
    bus8.load = 1'b0;
    bus8.en   = 1'b1;
    bus8.up   = 1'b1;
    #1;
    check("f8_up_tc", 32'(bus8.tc), 32'd1);
    tick();
    check("f8_up_q", 32'(bus8.q), 32'd0);
    check("f8_up_wrap", 32'(bus8.wrap), 32'd1);
    bus8.up = 1'b0;
    #1;
    check("f8_dn_tc", 32'(bus8.tc), 32'd1);
    tick();
    check("f8_dn_q", 32'(bus8.q), 32'd7);
    check("f8_dn_wrap", 32'(bus8.wrap), 32'd1);
    check("f8_dn_nq", 32'(bus8.nq), 32'd0);
    tick();
    check("f8_dn2_q", 32'(bus8.q), 32'd6);
    check("f8_dn2_wrap", 32'(bus8.wrap), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
